awg_cmd_ctrl: RTL and testbench
===============================

Name: awg_cmd_ctrl

Overview:
- Parses the UART receive byte stream into multi-byte ASCII commands, e.g. "F2500<CR>".
- Owns the AWG configuration registers (frequency word, amplitude, phase, waveform select) that feed the DDS/waveform datapath.
- Issues a one-cycle update strobe whenever any register changes.
- Replaces single-byte preset selection with arbitrary-value configuration.

Parameters:
- FREQ_W, 14: width of state_freq.
- FREQ_DEF, 1000: reset value of state_freq.
- AMP_DEF, 50: reset value of state_amp.
- PHASE_DEF, 50: reset value of state_phase.
- WAVE_DEF, 3: reset value of state (waveform select).
- MAX_DIGITS, 5: maximum decimal digits per command.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  received byte from the UART receiver.
- rx_valid  input  1  one-cycle strobe; rx_data is valid in this cycle.
- state  output  5  waveform select.
- state_freq  output  FREQ_W  frequency tuning value.
- state_amp  output  8  amplitude code.
- state_phase  output  8  phase offset.
- cfg_update  output  1  one-cycle pulse: a configuration register changed.
- cmd_err  output  1  one-cycle pulse: malformed command.
- busy  output  1  high while a command is in progress (FSM not IDLE).
- sweep_tick  input  1  present only with SWEEP_EN; one-cycle sweep step request.

Behaviour:
- Reset values:
  - state=WAVE_DEF, state_freq=FREQ_DEF, state_amp=AMP_DEF, state_phase=PHASE_DEF.
  - cfg_update=0, cmd_err=0, FSM=IDLE, accumulator=0, digit count=0, sweep step=0.
- Reset asserted mid-command aborts the command with no partial register write.
- Bytes are consumed only in cycles with rx_valid=1. Back-to-back valid bytes on consecutive cycles must be accepted.
- FSM states: IDLE, FIELD, DRAIN.
- IDLE:
  - 'F','A','P','W' (0x46,0x41,0x50,0x57): latch the target field, clear accumulator and digit count, go to FIELD.
  - CR (0x0D) and LF (0x0A): ignored.
  - Any other byte: cmd_err pulse, stay in IDLE.
- FIELD:
  - Digit '0'-'9': acc = acc*10 + digit, count += 1. Accumulator is 17 bits unsigned, so 99999 never overflows.
  - A digit that would make count exceed MAX_DIGITS: cmd_err pulse, go to DRAIN.
  - CR/LF with count>=1 and acc within the field range: commit, then go to IDLE.
    - Field ranges: F <= 2^FREQ_W-1, A <= 255, P <= 255, W <= 31.
  - CR/LF with count=0 or acc out of range: cmd_err pulse, no write, go to IDLE.
  - Any other byte: cmd_err pulse, go to DRAIN.
- DRAIN: discard bytes until CR/LF, then go to IDLE. No further cmd_err pulses in DRAIN.
- Commit latency:
  - Terminator accepted in cycle N: target register holds the new value and cfg_update=1 in cycle N+1.
  - cfg_update pulses even if the new value equals the old one.
- cmd_err is registered: it asserts in the cycle after the offending byte.
- Outputs change only on commit (or sweep). They hold their values through errors and DRAIN.

Optional Feature:
- Macro: AWG_SWEEP_EN.
- With the macro:
  - 'S' (0x53) is a valid command letter; range 0..2^FREQ_W-1. Its commit writes sweep_step and does not pulse cfg_update.
  - On each sweep_tick with sweep_step != 0: state_freq += sweep_step, modulo 2^FREQ_W (wrap), and cfg_update pulses next cycle.
  - sweep_step=0 disables the sweep.
  - An 'F' commit and sweep_tick in the same cycle: the commit wins and the tick is dropped.
  - Ticks are honoured in every FSM state.
- Without the macro: no sweep_tick port, and 'S' in IDLE is an illegal byte (cmd_err).

Decomposition:
- Shared package awg_cmd_pkg holds:
  - ASCII constants (CR, LF, '0', '9', and the command letters).
  - Field-select encoding (FLD_F, FLD_A, FLD_P, FLD_W, FLD_S).
  - FSM state encoding.
  - Per-field maximum values.
- One sub-module, dec_acc: the decimal digit accumulator.
  - Inputs: clear, digit strobe, digit value.
  - Outputs: 17-bit value, digit count, too_many flag.

Test Plan:
1. Reset with no traffic -> state=3, state_freq=1000, state_amp=50, state_phase=50, cfg_update=0, busy=0.
2. "F2500\r" back-to-back, CR accepted in cycle N -> state_freq=2500 and cfg_update=1 in N+1 only; cmd_err stays 0; busy falls with the commit.
3. "A300\r" -> one cmd_err, state_amp stays 50, no cfg_update. "F123456\r" -> cmd_err after the 6th digit, DRAIN, state_freq unchanged.
4. "P7x9\r" -> cmd_err after 'x', CR returns to IDLE, phase stays 50. Then "P90\r" -> state_phase=90 with a cfg_update pulse.
5. "F\r" -> cmd_err, no write. Then "F12", rst pulse, "W1\r" -> after rst all defaults restored; after W1 state=1; state_freq=1000.
6. AWG_SWEEP_EN: "S1000\r", "F16000\r", then sweep_tick -> state_freq=616 (wrap) with a cfg_update pulse. Next, sweep_tick in the same cycle as the "F200\r" commit -> state_freq=200.

Source files
------------

// File: rtl/awg_cmd_pkg.sv
// awg_cmd_pkg: ASCII codes, field/FSM encodings and field limits shared by awg_cmd_ctrl.
// Field limits for F/S depend on FREQ_W, so they come from fld_max().
package awg_cmd_pkg;
    localparam int ACC_W = 17;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_9  = 8'h39;
    localparam logic [7:0] ASC_F  = 8'h46;
    localparam logic [7:0] ASC_A  = 8'h41;
    localparam logic [7:0] ASC_P  = 8'h50;
    localparam logic [7:0] ASC_W  = 8'h57;
    localparam logic [7:0] ASC_S  = 8'h53;
    localparam logic [ACC_W-1:0] AMP_MAX   = 17'd255;
    localparam logic [ACC_W-1:0] PHASE_MAX = 17'd255;
    localparam logic [ACC_W-1:0] WAVE_MAX  = 17'd31;
    typedef enum logic [2:0] {FLD_F, FLD_A, FLD_P, FLD_W, FLD_S} fld_e;
    typedef enum logic [1:0] {ST_IDLE, ST_FIELD, ST_DRAIN} fsm_e;
    function automatic logic [ACC_W-1:0] fld_max(fld_e f, int freq_w);
        logic [ACC_W-1:0] fmax;
        fmax = (ACC_W'(1) << freq_w) - ACC_W'(1);
        return (f == FLD_A) ? AMP_MAX : (f == FLD_P) ? PHASE_MAX : (f == FLD_W) ? WAVE_MAX : fmax;
    endfunction
    function automatic logic is_term(logic [7:0] b);
        return (b == ASC_CR) || (b == ASC_LF);
    endfunction
    function automatic logic is_digit(logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction
endpackage

// File: rtl/awg_cmd_ctrl_if.sv
// awg_cmd_ctrl_if: UART byte input and AWG configuration outputs of awg_cmd_ctrl.
// sweep_tick exists only when AWG_SWEEP_EN is defined.
interface awg_cmd_ctrl_if #(parameter int FREQ_W = 14);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [4:0]        state;
    logic [FREQ_W-1:0] state_freq;
    logic [7:0]        state_amp;
    logic [7:0]        state_phase;
    logic              cfg_update;
    logic              cmd_err;
    logic              busy;
`ifdef AWG_SWEEP_EN
    logic              sweep_tick;
    modport master (output rx_data, rx_valid, sweep_tick,
                    input state, state_freq, state_amp, state_phase, cfg_update, cmd_err, busy);
    modport slave  (input rx_data, rx_valid, sweep_tick,
                    output state, state_freq, state_amp, state_phase, cfg_update, cmd_err, busy);
`else
    modport master (output rx_data, rx_valid,
                    input state, state_freq, state_amp, state_phase, cfg_update, cmd_err, busy);
    modport slave  (input rx_data, rx_valid,
                    output state, state_freq, state_amp, state_phase, cfg_update, cmd_err, busy);
`endif
endinterface

// File: rtl/awg_cmd_ctrl_dec_acc.sv
// dec_acc: decimal digit accumulator; too_many_o flags a digit beyond MAX_DIGITS,
// which is then not accumulated.
module dec_acc
    import awg_cmd_pkg::*;
#(
    parameter int MAX_DIGITS = 5,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             dig_i,
    input  logic [3:0]       val_i,
    output logic [ACC_W-1:0] acc_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             too_many_o
);
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             take;

    always_comb begin
        too_many_o = dig_i && (cnt_q == CNT_W'(MAX_DIGITS));
        take       = dig_i && !too_many_o;
        acc_d      = clr_i ? '0 : take ? (acc_q << 3) + (acc_q << 1) + ACC_W'(val_i) : acc_q;
        cnt_d      = clr_i ? '0 : take ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o = acc_q;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/awg_cmd_ctrl.sv
// awg_cmd_ctrl: parses ASCII commands (letter, decimal digits, CR/LF) into AWG config registers.
// Define AWG_SWEEP_EN to add the 'S' sweep-step command and the sweep_tick frequency stepper.
module awg_cmd_ctrl
    import awg_cmd_pkg::*;
#(
    parameter int FREQ_W     = 14,
    parameter int FREQ_DEF   = 1000,
    parameter int AMP_DEF    = 50,
    parameter int PHASE_DEF  = 50,
    parameter int WAVE_DEF   = 3,
    parameter int MAX_DIGITS = 5
) (
    input logic          clk,
    input logic          rst,
    awg_cmd_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    fsm_e              fsm_q;
    fld_e              fld_q, fld_d;
    logic [FREQ_W-1:0] freq_q;
    logic [7:0]        amp_q, phase_q;
    logic [4:0]        wave_q;
    logic              upd_q, err_q;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              too_many, is_letter, term, digit, acc_clr, acc_dig, commit;
`ifdef AWG_SWEEP_EN
    logic [FREQ_W-1:0] step_q;
    logic              tick_ok;
`endif

    always_comb begin
        term    = is_term(bus.rx_data);
        digit   = is_digit(bus.rx_data);
        fld_d   = (bus.rx_data == ASC_A) ? FLD_A : (bus.rx_data == ASC_P) ? FLD_P :
                  (bus.rx_data == ASC_W) ? FLD_W : (bus.rx_data == ASC_S) ? FLD_S : FLD_F;
`ifdef AWG_SWEEP_EN
        is_letter = bus.rx_data inside {ASC_F, ASC_A, ASC_P, ASC_W, ASC_S};
`else
        is_letter = bus.rx_data inside {ASC_F, ASC_A, ASC_P, ASC_W};
`endif
        acc_clr = bus.rx_valid && (fsm_q == ST_IDLE) && is_letter;
        acc_dig = bus.rx_valid && (fsm_q == ST_FIELD) && digit;
        commit  = bus.rx_valid && (fsm_q == ST_FIELD) && term && (cnt != '0) &&
                  (acc <= fld_max(fld_q, FREQ_W));
`ifdef AWG_SWEEP_EN
        // A same-cycle F commit overrides the frequency, so the tick is dropped
        tick_ok = bus.sweep_tick && (step_q != '0) && !(commit && fld_q == FLD_F);
`endif
    end

    dec_acc #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_dec_acc (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (acc_clr),
        .dig_i     (acc_dig),
        .val_i     (bus.rx_data[3:0]),
        .acc_o     (acc),
        .cnt_o     (cnt),
        .too_many_o(too_many)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            fld_q   <= FLD_F;
            freq_q  <= FREQ_W'(FREQ_DEF);
            amp_q   <= 8'(AMP_DEF);
            phase_q <= 8'(PHASE_DEF);
            wave_q  <= 5'(WAVE_DEF);
            upd_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef AWG_SWEEP_EN
            step_q  <= '0;
`endif
        end else begin
            err_q <= 1'b0;
`ifdef AWG_SWEEP_EN
            upd_q <= tick_ok || (commit && fld_q != FLD_S);
            if (tick_ok)
                freq_q <= freq_q + step_q;
`else
            upd_q <= commit;
`endif
            if (commit) begin
                case (fld_q)
                    FLD_F: freq_q  <= acc[FREQ_W-1:0];
                    FLD_A: amp_q   <= acc[7:0];
                    FLD_P: phase_q <= acc[7:0];
                    FLD_W: wave_q  <= acc[4:0];
`ifdef AWG_SWEEP_EN
                    FLD_S: step_q  <= acc[FREQ_W-1:0];
`endif
                    default: ;
                endcase
            end
            case (fsm_q)
                ST_IDLE: if (bus.rx_valid) begin
                    if (is_letter) begin
                        fld_q <= fld_d;
                        fsm_q <= ST_FIELD;
                    end else if (!term) begin
                        err_q <= 1'b1;
                    end
                end
                ST_FIELD: if (bus.rx_valid) begin
                    if (term) begin
                        fsm_q <= ST_IDLE;
                        err_q <= !commit;
                    end else if (!digit || too_many) begin
                        err_q <= 1'b1;
                        fsm_q <= ST_DRAIN;
                    end
                end
                default: if (bus.rx_valid && term) fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.state       = wave_q;
    assign bus.state_freq  = freq_q;
    assign bus.state_amp   = amp_q;
    assign bus.state_phase = phase_q;
    assign bus.cfg_update  = upd_q;
    assign bus.cmd_err     = err_q;
    assign bus.busy        = fsm_q != ST_IDLE;
endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// tb_awg_cmd_ctrl: table-driven, hand-written and random checks of awg_cmd_ctrl against a
// line-buffer command model; sweep checks compile in with AWG_SWEEP_EN.
module tb_awg_cmd_ctrl;
    localparam int FMAX = 16383;

    typedef struct {
        string s;
        int    freq, amp, ph, wave, errs, upds;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    int   checks = 0;
    int   errors = 0;

    int   m_freq, m_amp, m_ph, m_wave, m_sstep;
    bit   m_upd, m_err, dead;
    logic [7:0] line[$];

    awg_cmd_ctrl_if #(.FREQ_W(14)) bus ();
    awg_cmd_ctrl #(.FREQ_W(14)) dut (.clk(clk), .rst(rst), .bus(bus));
`ifdef AWG_SWEEP_EN
    assign bus.sweep_tick = tick;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_letter(logic [7:0] b);
`ifdef AWG_SWEEP_EN
        return b == "F" || b == "A" || b == "P" || b == "W" || b == "S";
`else
        return b == "F" || b == "A" || b == "P" || b == "W";
`endif
    endfunction

    function automatic bit is_term(logic [7:0] b);
        return b == 8'h0D || b == 8'h0A;
    endfunction

    function automatic int lim(logic [7:0] b);
        return (b == "A" || b == "P") ? 255 : (b == "W") ? 31 : FMAX;
    endfunction

    task automatic model_reset();
        m_freq = 1000; m_amp = 50; m_ph = 50; m_wave = 3; m_sstep = 0;
        m_upd = 0; m_err = 0; dead = 0;
        line.delete();
    endtask

    // Commands are judged on the text of the current line, not on parser state
    task automatic model_step(input logic [7:0] d, input bit v, input bit t);
        int  old_step = m_sstep;
        bit  cf = 0;
        m_upd = 0;
        m_err = 0;
        if (v) begin
            if (line.size() == 0) begin
                if (is_letter(d)) line.push_back(d);
                else if (!is_term(d)) m_err = 1;
            end else if (dead) begin
                if (is_term(d)) begin line.delete(); dead = 0; end
            end else if (is_term(d)) begin
                int val = 0;
                for (int i = 1; i < line.size(); i++) val = val * 10 + int'(line[i] - 8'h30);
                if (line.size() == 1 || val > lim(line[0])) m_err = 1;
                else begin
                    case (line[0])
                        "F": begin m_freq = val; cf = 1; m_upd = 1; end
                        "A": begin m_amp = val; m_upd = 1; end
                        "P": begin m_ph = val; m_upd = 1; end
                        "W": begin m_wave = val; m_upd = 1; end
                        default: m_sstep = val;
                    endcase
                end
                line.delete();
            end else if (d >= "0" && d <= "9" && line.size() < 6) begin
                line.push_back(d);
            end else begin
                m_err = 1;
                dead = 1;
            end
        end
`ifdef AWG_SWEEP_EN
        if (t && old_step != 0 && !cf) begin
            m_freq = (m_freq + old_step) % (FMAX + 1);
            m_upd = 1;
        end
`else
        if (t && old_step != 0 && !cf) m_upd = m_upd;
`endif
    endtask

    task automatic cyc(input logic [7:0] d, input bit v, input bit t);
        bus.rx_data = d;
        bus.rx_valid = v;
        tick = t;
        model_step(d, v, t);
        @(posedge clk);
        @(negedge clk);
        chk("state", 32'(bus.state), m_wave);
        chk("state_freq", 32'(bus.state_freq), m_freq);
        chk("state_amp", 32'(bus.state_amp), m_amp);
        chk("state_phase", 32'(bus.state_phase), m_ph);
        chk("cfg_update", 32'(bus.cfg_update), 32'(m_upd));
        chk("cmd_err", 32'(bus.cmd_err), 32'(m_err));
        chk("busy", 32'(bus.busy), 32'(line.size() != 0));
        bus.rx_valid = 1'b0;
        tick = 1'b0;
    endtask

    task automatic apply(input string s, output int ne, output int nu);
        ne = 0;
        nu = 0;
        for (int i = 0; i < s.len(); i++) begin
            cyc(s[i], 1'b1, 1'b0);
            ne += int'(bus.cmd_err);
            nu += int'(bus.cfg_update);
        end
    endtask

    function automatic bit rtick();
        return $urandom_range(0, 7) == 0;
    endfunction

    task automatic send(input logic [7:0] b);
        if ($urandom_range(0, 3) == 0) cyc(8'($urandom), 1'b0, rtick());
        cyc(b, 1'b1, rtick());
    endtask

    initial begin
        vec_t tbl[18];
        int   ne, nu;
        tbl[0]  = '{"F2500\015",   2500, 50, 50, 3, 0, 1};
        tbl[1]  = '{"A300\015",    2500, 50, 50, 3, 1, 0};
        tbl[2]  = '{"F123456\015", 2500, 50, 50, 3, 1, 0};
        tbl[3]  = '{"P7x9\015",    2500, 50, 50, 3, 1, 0};
        tbl[4]  = '{"P90\015",     2500, 50, 90, 3, 0, 1};
        tbl[5]  = '{"F\015",       2500, 50, 90, 3, 1, 0};
        tbl[6]  = '{"\015\012",    2500, 50, 90, 3, 0, 0};
        tbl[7]  = '{"W31\012",     2500, 50, 90, 31, 0, 1};
        tbl[8]  = '{"W32\015",     2500, 50, 90, 31, 1, 0};
        tbl[9]  = '{"F16383\015",  16383, 50, 90, 31, 0, 1};
        tbl[10] = '{"F16384\015",  16383, 50, 90, 31, 1, 0};
        tbl[11] = '{"Zq\015",      16383, 50, 90, 31, 2, 0};
        tbl[12] = '{"A255\015",    16383, 255, 90, 31, 0, 1};
        tbl[13] = '{"F00007\015",  7, 255, 90, 31, 0, 1};
        tbl[14] = '{"F99999\015",  7, 255, 90, 31, 1, 0};
        tbl[15] = '{"A0\015",      7, 0, 90, 31, 0, 1};
        tbl[16] = '{"A0\015",      7, 0, 90, 31, 0, 1};
        tbl[17] = '{"F1A\015",     7, 0, 90, 31, 1, 0};

        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset state", 32'(bus.state), 3);
        chk("reset freq", 32'(bus.state_freq), 1000);
        chk("reset amp", 32'(bus.state_amp), 50);
        chk("reset phase", 32'(bus.state_phase), 50);
        chk("reset cfg_update", 32'(bus.cfg_update), 0);
        chk("reset busy", 32'(bus.busy), 0);

        foreach (tbl[k]) begin
            apply(tbl[k].s, ne, nu);
            chk($sformatf("vec%0d freq", k), 32'(bus.state_freq), tbl[k].freq);
            chk($sformatf("vec%0d amp", k), 32'(bus.state_amp), tbl[k].amp);
            chk($sformatf("vec%0d phase", k), 32'(bus.state_phase), tbl[k].ph);
            chk($sformatf("vec%0d wave", k), 32'(bus.state), tbl[k].wave);
            chk($sformatf("vec%0d errs", k), ne, tbl[k].errs);
            chk($sformatf("vec%0d upds", k), nu, tbl[k].upds);
        end

        apply("F2500", ne, nu);
        chk("cmd busy", 32'(bus.busy), 1);
        cyc(8'h0D, 1'b1, 1'b0);
        chk("commit freq", 32'(bus.state_freq), 2500);
        chk("commit pulse", 32'(bus.cfg_update), 1);
        chk("commit busy", 32'(bus.busy), 0);
        cyc(8'h00, 1'b0, 1'b0);
        chk("pulse one cycle", 32'(bus.cfg_update), 0);
        chk("no err", 32'(bus.cmd_err), 0);

        apply("F12", ne, nu);
        rst = 1'b1;
        #1;
        model_reset();
        chk("async rst freq", 32'(bus.state_freq), 1000);
        chk("async rst amp", 32'(bus.state_amp), 50);
        chk("async rst phase", 32'(bus.state_phase), 50);
        chk("async rst wave", 32'(bus.state), 3);
        chk("async rst busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        apply("W1\015", ne, nu);
        chk("post-rst wave", 32'(bus.state), 1);
        chk("post-rst freq", 32'(bus.state_freq), 1000);

`ifdef AWG_SWEEP_EN
        apply("S1000\015", ne, nu);
        chk("S commit no pulse", nu, 0);
        apply("F16000\015", ne, nu);
        cyc(8'h00, 1'b0, 1'b1);
        chk("sweep wrap freq", 32'(bus.state_freq), 616);
        chk("sweep pulse", 32'(bus.cfg_update), 1);
        apply("F200", ne, nu);
        cyc(8'h0D, 1'b1, 1'b1);
        chk("commit beats tick", 32'(bus.state_freq), 200);
        cyc(8'h00, 1'b0, 1'b0);
        chk("tick dropped", 32'(bus.state_freq), 200);
        apply("S0\015", ne, nu);
        cyc(8'h00, 1'b0, 1'b1);
        chk("step0 no pulse", 32'(bus.cfg_update), 0);
        chk("step0 freq", 32'(bus.state_freq), 200);
`endif

        for (int c = 0; c < 400; c++) begin
            int n;
            logic [7:0] b;
            case ($urandom_range(0, 9))
                0, 5: b = "F";
                1, 6: b = "A";
                2: b = "P";
                3: b = "W";
                4: b = "S";
                7: b = "Z";
                8: b = "5";
                default: b = 8'h0D;
            endcase
            send(b);
            n = $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 7);
            for (int k = 0; k < n; k++)
                send(($urandom_range(0, 30) == 0) ? 8'h78 : 8'(8'h30 + $urandom_range(0, 9)));
            send($urandom_range(0, 1) ? 8'h0D : 8'h0A);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
